// File: rtl/gcd_driver_if.sv
// Request/response and GCD-core-side signal bundle for gcd_driver.
// The master modport is the driver itself; slave is the host plus core side.
interface gcd_driver_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [WIDTH-1:0] num_A;
    logic [WIDTH-1:0] num_B;
    logic             button;
    logic [WIDTH-1:0] LED_out;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_gcd;
    logic             rsp_timeout;
    logic             busy;

    modport master (
        input  req_valid, req_a, req_b, LED_out, rsp_ready,
        output req_ready, num_A, num_B, button, rsp_valid, rsp_gcd, rsp_timeout, busy
    );

    modport slave (
        output req_valid, req_a, req_b, LED_out, rsp_ready,
        input  req_ready, num_A, num_B, button, rsp_valid, rsp_gcd, rsp_timeout, busy
    );
endinterface

// File: rtl/gcd_driver.sv
// Operand sequencer for the GCD core: accept, load, press button, wait for LED_out to settle, respond.
// Optional feature macro: GCD_DRV_ZERO_BYPASS_EN (zero operand answers directly without using the core).
module gcd_driver #(
    parameter int WIDTH          = 8,
    parameter int HOLD_CYCLES    = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic        clk,
    input logic        rst,
    gcd_driver_if.master bus
);

    typedef enum logic [2:0] {IDLE, LOAD, PRESS, WAIT, RESP} state_e;

    localparam int MAX_HS = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_P  = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q;
    logic [WIDTH-1:0] numA_q;
    logic [WIDTH-1:0] numB_q;
    logic [WIDTH-1:0] prevLed_q;
    logic [WIDTH-1:0] rspGcd_q;
    logic             button_q;
    logic             rspTimeout_q;
    logic [CNT_W-1:0] holdCnt_q;
    logic [CNT_W-1:0] stableCnt_q;
    logic [CNT_W-1:0] timeoutCnt_q;
    logic [CNT_W-1:0] stableCnt_d;
    logic [CNT_W-1:0] timeoutCnt_d;
    logic             ledSame;
`ifdef GCD_DRV_ZERO_BYPASS_EN
    logic             bypass_q;
`endif

    // Saturating next values of the settle and timeout counters seen in WAIT
    always_comb begin
        ledSame      = (bus.LED_out == prevLed_q);
        stableCnt_d  = '0;
        timeoutCnt_d = (timeoutCnt_q == CNT_MAX) ? timeoutCnt_q : timeoutCnt_q + 1'b1;
        if (ledSame) begin
            stableCnt_d = (stableCnt_q == CNT_MAX) ? stableCnt_q : stableCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            numA_q       <= '0;
            numB_q       <= '0;
            prevLed_q    <= '0;
            rspGcd_q     <= '0;
            button_q     <= 1'b0;
            rspTimeout_q <= 1'b0;
            holdCnt_q    <= '0;
            stableCnt_q  <= '0;
            timeoutCnt_q <= '0;
`ifdef GCD_DRV_ZERO_BYPASS_EN
            bypass_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        numA_q  <= bus.req_a;
                        numB_q  <= bus.req_b;
                        state_q <= LOAD;
`ifdef GCD_DRV_ZERO_BYPASS_EN
                        bypass_q <= (bus.req_a == '0) || (bus.req_b == '0);
`endif
                    end
                end
                LOAD: begin
`ifdef GCD_DRV_ZERO_BYPASS_EN
                    // A zero operand makes the answer the other operand, so skip the core
                    if (bypass_q) begin
                        rspGcd_q     <= numA_q | numB_q;
                        rspTimeout_q <= 1'b0;
                        state_q      <= RESP;
                    end else
`endif
                    begin
                        button_q  <= 1'b1;
                        holdCnt_q <= '0;
                        state_q   <= PRESS;
                    end
                end
                PRESS: begin
                    if (holdCnt_q == HOLD_LAST) begin
                        button_q     <= 1'b0;
                        prevLed_q    <= bus.LED_out;
                        stableCnt_q  <= '0;
                        timeoutCnt_q <= '0;
                        state_q      <= WAIT;
                    end else begin
                        holdCnt_q <= holdCnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    stableCnt_q  <= stableCnt_d;
                    timeoutCnt_q <= timeoutCnt_d;
                    if (!ledSame) begin
                        prevLed_q <= bus.LED_out;
                    end
                    // Settling is tested first so it wins when both happen together
                    if (stableCnt_d >= SETTLE_CNT) begin
                        rspGcd_q     <= bus.LED_out;
                        rspTimeout_q <= 1'b0;
                        state_q      <= RESP;
                    end else if (timeoutCnt_d >= TIMEOUT_CNT) begin
                        rspGcd_q     <= bus.LED_out;
                        rspTimeout_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.num_A       = numA_q;
    assign bus.num_B       = numB_q;
    assign bus.button      = button_q;
    assign bus.rsp_gcd     = rspGcd_q;
    assign bus.rsp_timeout = rspTimeout_q;

endmodule

// File: tb/tb_gcd_driver.sv
// Directed self-checking bench for gcd_driver with a behavioral GCD core on LED_out.
// Honours GCD_DRV_ZERO_BYPASS_EN for the zero-operand vector.
module tb_gcd_driver;

    logic clk;
    logic rst;
    logic toggleMode;
    int   errCount;
    int   checkCount;

    gcd_driver_if #(.WIDTH(8)) bus ();

    gcd_driver #(
        .WIDTH(8),
        .HOLD_CYCLES(8),
        .SETTLE_CYCLES(4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gcdModel(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] t;
        x = a;
        y = b;
        for (int i = 0; i < 32 && y != 0; i++) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core model: LED_out changes only on falling edges, so the driver always samples a steady value
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            bus.LED_out <= 8'd0;
        end else if (toggleMode) begin
            bus.LED_out <= ~bus.LED_out;
        end else if (bus.button) begin
            bus.LED_out <= gcdModel(bus.num_A, bus.num_B);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One full transaction starting #1 after an edge with the driver idle
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] expGcd,
                                 input logic expTimeout, input int expLat, input int expBtn,
                                 input int holdCycles, input bit expFromLed);
        int         lat;
        int         btnCnt;
        logic       readyLow;
        logic [7:0] want;
        logic [7:0] heldGcd;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (holdCycles == 0);
        checkOutput("req_ready_idle", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat      = 0;
        btnCnt   = 0;
        readyLow = 1'b1;
        while (!bus.rsp_valid && lat < 400) begin
            if (bus.button) btnCnt++;
            if (bus.req_ready) readyLow = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        want = expFromLed ? bus.LED_out : expGcd;
        checkOutput("rsp_valid_seen", bus.rsp_valid, 1'b1);
        checkOutput("latency", lat, expLat);
        checkOutput("button_cycles", btnCnt, expBtn);
        checkOutput("req_ready_low", readyLow, 1'b1);
        checkOutput("rsp_gcd", bus.rsp_gcd, want);
        checkOutput("rsp_timeout", bus.rsp_timeout, expTimeout);
        checkOutput("num_A", bus.num_A, a);
        checkOutput("num_B", bus.num_B, b);
        heldGcd = bus.rsp_gcd;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_rsp_valid", bus.rsp_valid, 1'b1);
            checkOutput("hold_rsp_gcd", bus.rsp_gcd, want);
            checkOutput("hold_req_ready", bus.req_ready, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("post_req_ready", bus.req_ready, 1'b1);
        checkOutput("post_num_A", bus.num_A, a);
        if (heldGcd !== want) checkOutput("held_gcd", heldGcd, want);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        errCount      = 0;
        checkCount    = 0;
        toggleMode    = 1'b0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = 8'd0;
        bus.req_b     = 8'd0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", bus.req_ready, 1'b1);
        checkOutput("reset_busy", bus.busy, 1'b0);
        checkOutput("reset_button", bus.button, 1'b0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("reset_num_A", bus.num_A, 8'd0);
        checkOutput("reset_num_B", bus.num_B, 8'd0);
        checkOutput("reset_rsp_gcd", bus.rsp_gcd, 8'd0);
        checkOutput("reset_rsp_timeout", bus.rsp_timeout, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic 148,60");
        applyStimulus(8'd148, 8'd60, 8'd4, 1'b0, 13, 8, 0, 1'b0);

        $display("[TB] back-to-back 22,55 then 88,50");
        applyStimulus(8'd22, 8'd55, 8'd11, 1'b0, 13, 8, 0, 1'b0);
        applyStimulus(8'd88, 8'd50, 8'd2, 1'b0, 13, 8, 0, 1'b0);

        $display("[TB] response held 20 cycles");
        applyStimulus(8'd36, 8'd24, 8'd12, 1'b0, 13, 8, 20, 1'b0);

        $display("[TB] toggling LED_out forces timeout");
        toggleMode = 1'b1;
        applyStimulus(8'd9, 8'd6, 8'd0, 1'b1, 264, 8, 0, 1'b1);
        toggleMode = 1'b0;

        $display("[TB] reset during PRESS");
        bus.req_a     = 8'd148;
        bus.req_b     = 8'd60;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("press_button", bus.button, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_button", bus.button, 1'b0);
        checkOutput("async_rsp_valid", bus.rsp_valid, 1'b0);
        checkOutput("async_num_A", bus.num_A, 8'd0);
        checkOutput("async_num_B", bus.num_B, 8'd0);
        checkOutput("async_busy", bus.busy, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_reset_idle", bus.req_ready, 1'b1);
        applyStimulus(8'd22, 8'd55, 8'd11, 1'b0, 13, 8, 0, 1'b0);

        $display("[TB] zero operand 0,9");
`ifdef GCD_DRV_ZERO_BYPASS_EN
        applyStimulus(8'd0, 8'd9, 8'd9, 1'b0, 1, 0, 0, 1'b0);
`else
        applyStimulus(8'd0, 8'd9, 8'd9, 1'b0, 13, 8, 0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
